// File: rtl/branch_ctrl_if.sv
// ============================================================================
// branch_ctrl_if : ID-stage branch controller bus (decode, hazard, outputs)
// Rev 1.0
// ============================================================================
`default_nettype none

interface branch_ctrl_if #(
    parameter int AW  = 5,
    parameter int PCW = 32
);
    logic           id_valid;
    logic           id_is_branch;
    logic [2:0]     id_br_type;
    logic [AW-1:0]  id_rs;
    logic [AW-1:0]  id_rt;
    logic           id_uses_rt;
    logic [PCW-1:0] id_target;
    logic           ex_wr_en;
    logic [AW-1:0]  ex_wr_addr;
    logic           mem_wr_en;
    logic [AW-1:0]  mem_wr_addr;
    logic           mem_is_load;
    logic           wb_wr_en;
    logic [AW-1:0]  wb_wr_addr;
    logic           cmp_result;
    logic [2:0]     cmp_sel;
    logic [1:0]     fwd_a_sel;
    logic [1:0]     fwd_b_sel;
    logic           stall;
    logic           redirect;
    logic [PCW-1:0] redirect_pc;
    logic           squash_if;

    modport master (
        output id_valid, id_is_branch, id_br_type, id_rs, id_rt, id_uses_rt,
               id_target, ex_wr_en, ex_wr_addr, mem_wr_en, mem_wr_addr,
               mem_is_load, wb_wr_en, wb_wr_addr, cmp_result,
        input  cmp_sel, fwd_a_sel, fwd_b_sel, stall, redirect, redirect_pc,
               squash_if
    );

    modport slave (
        input  id_valid, id_is_branch, id_br_type, id_rs, id_rt, id_uses_rt,
               id_target, ex_wr_en, ex_wr_addr, mem_wr_en, mem_wr_addr,
               mem_is_load, wb_wr_en, wb_wr_addr, cmp_result,
        output cmp_sel, fwd_a_sel, fwd_b_sel, stall, redirect, redirect_pc,
               squash_if
    );
endinterface

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
// branch_ctrl : ID-stage branch sequencer (hazard stall, forwarding, redirect)
// Optional statistics counters enabled by macro BRANCH_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module branch_ctrl #(
    parameter int AW  = 5,
    parameter int PCW = 32
) (
    input  logic         clk,
    input  logic         reset,
    branch_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]  br_count,
    output logic [31:0]  taken_count,
    output logic [31:0]  stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    state_t         state_q, state_d;
    logic           redirect_q, redirect_d;
    logic           squash_if_q, squash_if_d;
    logic [PCW-1:0] redirect_pc_q, redirect_pc_d;

    logic           br_in_id;
    logic           active;
    logic           haz_a, haz_b, hazard;
    logic           stall_w;
    logic           resolve_w;
    logic           taken_w;
    logic           type_ok;
    logic [1:0]     fwd_a_w, fwd_b_w;

    // r0 is hardwired to zero, so it can never match an in-flight writer.
    function automatic logic writer_hit(input logic [AW-1:0] r,
                                        input logic          en,
                                        input logic [AW-1:0] addr);
        return en && (r != {AW{1'b0}}) && (r == addr);
    endfunction

    function automatic logic [1:0] fwd_pick(input logic [AW-1:0] r,
                                            input logic          mem_alu_en,
                                            input logic [AW-1:0] mem_addr,
                                            input logic          wb_en,
                                            input logic [AW-1:0] wb_addr);
        logic [1:0] sel;
        sel = FWD_RF;
        if (writer_hit(r, mem_alu_en, mem_addr))
            sel = FWD_MEM;
        else if (writer_hit(r, wb_en, wb_addr))
            sel = FWD_WB;
        return sel;
    endfunction

    always_comb begin
        br_in_id = bus.id_valid && bus.id_is_branch;
        active   = (state_q != S_REDIR);

        haz_a = writer_hit(bus.id_rs, bus.ex_wr_en, bus.ex_wr_addr)
             || writer_hit(bus.id_rs, bus.mem_wr_en && bus.mem_is_load,
                           bus.mem_wr_addr);
        haz_b = bus.id_uses_rt
             && (writer_hit(bus.id_rt, bus.ex_wr_en, bus.ex_wr_addr)
              || writer_hit(bus.id_rt, bus.mem_wr_en && bus.mem_is_load,
                            bus.mem_wr_addr));
        hazard = haz_a || haz_b;

        fwd_a_w = fwd_pick(bus.id_rs, bus.mem_wr_en && !bus.mem_is_load,
                           bus.mem_wr_addr, bus.wb_wr_en, bus.wb_wr_addr);
        fwd_b_w = FWD_RF;
        if (bus.id_uses_rt)
            fwd_b_w = fwd_pick(bus.id_rt, bus.mem_wr_en && !bus.mem_is_load,
                               bus.mem_wr_addr, bus.wb_wr_en, bus.wb_wr_addr);

        // Codes 6/7 are undefined branch types and must never redirect.
        type_ok = (bus.id_br_type <= 3'd5);

        stall_w   = reset && br_in_id && hazard && active;
        resolve_w = br_in_id && !hazard && active;
        taken_w   = resolve_w && bus.cmp_result && type_ok;
    end

    always_comb begin
        state_d       = state_q;
        redirect_d    = 1'b0;
        squash_if_d   = 1'b0;
        redirect_pc_d = redirect_pc_q;

        case (state_q)
            S_IDLE, S_WAIT: begin
                if (!br_in_id) begin
                    state_d = S_IDLE;
                end else if (hazard) begin
                    state_d = S_WAIT;
                end else if (taken_w) begin
                    state_d       = S_REDIR;
                    redirect_d    = 1'b1;
                    squash_if_d   = 1'b1;
                    redirect_pc_d = bus.id_target;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIR: begin
                // Delay-slot instruction sits in ID now; any branch there is ignored.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            redirect_q    <= 1'b0;
            squash_if_q   <= 1'b0;
            redirect_pc_q <= {PCW{1'b0}};
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            squash_if_q   <= squash_if_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Combinational outputs are gated by reset so they drop as soon as it asserts.
    always_comb begin
        bus.cmp_sel     = (reset && br_in_id) ? bus.id_br_type : 3'd0;
        bus.fwd_a_sel   = reset ? fwd_a_w : FWD_RF;
        bus.fwd_b_sel   = reset ? fwd_b_w : FWD_RF;
        bus.stall       = stall_w;
        bus.redirect    = redirect_q;
        bus.squash_if   = squash_if_q;
        bus.redirect_pc = redirect_pc_q;
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q,    br_count_d;
    logic [31:0] taken_count_q, taken_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        br_count_d    = br_count_q    + {31'd0, resolve_w};
        taken_count_d = taken_count_q + {31'd0, taken_w};
        stall_count_d = stall_count_q + {31'd0, stall_w};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count_q    <= 32'd0;
            taken_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// tb_branch_ctrl : directed vector table plus multi-cycle sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    branch_ctrl_if #(.AW(5), .PCW(32)) bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count, taken_count, stall_count;
    branch_ctrl #(.AW(5), .PCW(32)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .br_count(br_count), .taken_count(taken_count), .stall_count(stall_count)
    );
`else
    branch_ctrl #(.AW(5), .PCW(32)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       valid;
        logic       is_br;
        logic [2:0] typ;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       ex_en;
        logic [4:0] ex_a;
        logic       mem_en;
        logic [4:0] mem_a;
        logic       mem_ld;
        logic       wb_en;
        logic [4:0] wb_a;
        logic       exp_stall;
        logic [2:0] exp_sel;
        logic [1:0] exp_fa;
        logic [1:0] exp_fb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add_vec(input logic v, input logic b, input logic [2:0] t,
                           input logic [4:0] rs, input logic [4:0] rt, input logic u,
                           input logic exe, input logic [4:0] exa,
                           input logic me, input logic [4:0] ma, input logic ml,
                           input logic we, input logic [4:0] wa,
                           input logic es, input logic [2:0] esel,
                           input logic [1:0] efa, input logic [1:0] efb);
        vec_t x;
        x.valid = v; x.is_br = b; x.typ = t; x.rs = rs; x.rt = rt; x.uses_rt = u;
        x.ex_en = exe; x.ex_a = exa; x.mem_en = me; x.mem_a = ma; x.mem_ld = ml;
        x.wb_en = we; x.wb_a = wa; x.exp_stall = es; x.exp_sel = esel;
        x.exp_fa = efa; x.exp_fb = efb;
        vecs.push_back(x);
    endtask

    task automatic set_idle();
        bus.id_valid = 0; bus.id_is_branch = 0; bus.id_br_type = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0; bus.id_target = 0;
        bus.ex_wr_en = 0; bus.ex_wr_addr = 0;
        bus.mem_wr_en = 0; bus.mem_wr_addr = 0; bus.mem_is_load = 0;
        bus.wb_wr_en = 0; bus.wb_wr_addr = 0; bus.cmp_result = 0;
    endtask

    task automatic set_br(input logic [2:0] t, input logic [4:0] rs, input logic [4:0] rt,
                          input logic u, input logic cmp, input logic [31:0] tgt);
        bus.id_valid = 1; bus.id_is_branch = 1; bus.id_br_type = t;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = u;
        bus.cmp_result = cmp; bus.id_target = tgt;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1;
        set_idle();
        #2 reset = 0;
        #1;
        check("reset stall",       {31'd0, bus.stall},     0);
        check("reset redirect",    {31'd0, bus.redirect},  0);
        check("reset squash_if",   {31'd0, bus.squash_if}, 0);
        check("reset redirect_pc", bus.redirect_pc,        0);
        check("reset cmp_sel",     {29'd0, bus.cmp_sel},   0);
        @(negedge clk);
        reset = 1;

        //       v b typ rs rt u  exe exa  me ma ml  we wa   stall sel fa fb
        add_vec(1,1,3'd0, 3, 4,1, 0, 0,   0, 0,0,  0, 0,   0, 0, 0, 0);
        add_vec(1,1,3'd1, 3, 4,1, 1, 4,   0, 0,0,  0, 0,   1, 1, 0, 0);
        add_vec(1,1,3'd1, 3, 4,0, 1, 4,   0, 0,0,  0, 0,   0, 1, 0, 0);
        add_vec(1,1,3'd2, 5, 0,0, 0, 0,   1, 5,1,  0, 0,   1, 2, 0, 0);
        add_vec(1,1,3'd3, 5, 0,0, 0, 0,   1, 5,0,  0, 0,   0, 3, 1, 0);
        add_vec(1,1,3'd4, 0, 0,0, 1, 0,   0, 0,0,  0, 0,   0, 4, 0, 0);
        add_vec(1,1,3'd5, 6, 0,0, 0, 0,   0, 0,0,  1, 6,   0, 5, 2, 0);
        add_vec(1,1,3'd0, 7, 7,1, 0, 0,   1, 7,0,  1, 7,   0, 0, 1, 1);
        add_vec(1,1,3'd0, 2, 9,1, 0, 0,   1, 2,0,  1, 9,   0, 0, 1, 2);
        add_vec(1,0,3'd3, 5, 0,0, 1, 5,   0, 0,0,  0, 0,   0, 0, 0, 0);
        add_vec(0,1,3'd2, 5, 0,0, 1, 5,   0, 0,0,  0, 0,   0, 0, 0, 0);
        add_vec(1,1,3'd0, 0, 8,1, 0, 0,   1, 8,1,  0, 0,   1, 0, 0, 0);
        add_vec(1,1,3'd0, 0, 0,1, 0, 0,   1, 0,0,  1, 0,   0, 0, 0, 0);
        add_vec(1,1,3'd5, 6, 6,0, 0, 0,   0, 0,0,  0, 6,   0, 5, 0, 0);
        add_vec(1,1,3'd0, 3, 6,0, 0, 0,   1, 6,0,  1, 6,   0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            set_idle();
            bus.id_valid = vecs[i].valid; bus.id_is_branch = vecs[i].is_br;
            bus.id_br_type = vecs[i].typ; bus.id_rs = vecs[i].rs; bus.id_rt = vecs[i].rt;
            bus.id_uses_rt = vecs[i].uses_rt;
            bus.ex_wr_en = vecs[i].ex_en; bus.ex_wr_addr = vecs[i].ex_a;
            bus.mem_wr_en = vecs[i].mem_en; bus.mem_wr_addr = vecs[i].mem_a;
            bus.mem_is_load = vecs[i].mem_ld;
            bus.wb_wr_en = vecs[i].wb_en; bus.wb_wr_addr = vecs[i].wb_a;
            #1;
            check($sformatf("vec%0d stall", i), {31'd0, bus.stall},     {31'd0, vecs[i].exp_stall});
            check($sformatf("vec%0d cmp_sel", i), {29'd0, bus.cmp_sel}, {29'd0, vecs[i].exp_sel});
            check($sformatf("vec%0d fwd_a", i), {30'd0, bus.fwd_a_sel}, {30'd0, vecs[i].exp_fa});
            check($sformatf("vec%0d fwd_b", i), {30'd0, bus.fwd_b_sel}, {30'd0, vecs[i].exp_fb});
            @(negedge clk);
            set_idle();
            @(negedge clk);
            check($sformatf("vec%0d no redirect", i), {31'd0, bus.redirect}, 0);
        end

        // Taken beq without hazard: redirect exactly in T+1.
        @(negedge clk);
        set_br(3'd0, 3, 4, 1, 1, 32'h0000_3010);
        #1;
        check("beq T stall",    {31'd0, bus.stall},    0);
        check("beq T redirect", {31'd0, bus.redirect}, 0);
        @(posedge clk); #1;
        check("beq T+1 redirect", {31'd0, bus.redirect},  1);
        check("beq T+1 squash",   {31'd0, bus.squash_if}, 1);
        check("beq T+1 pc",       bus.redirect_pc, 32'h0000_3010);
        @(negedge clk);
        set_idle();
        @(posedge clk); #1;
        check("beq T+2 redirect", {31'd0, bus.redirect},  0);
        check("beq T+2 squash",   {31'd0, bus.squash_if}, 0);

        // Not-taken bne: nothing happens.
        @(negedge clk);
        set_br(3'd1, 3, 4, 1, 0, 32'h0000_2000);
        #1;
        check("bne stall", {31'd0, bus.stall}, 0);
        @(posedge clk); #1;
        check("bne redirect", {31'd0, bus.redirect}, 0);
        check("bne pc held",  bus.redirect_pc, 32'h0000_3010);
        @(negedge clk);
        set_idle();

        // Load-use on r5: two stall cycles, then resolve via WB forward.
        @(negedge clk);
        set_br(3'd2, 5, 0, 0, 1, 32'h0000_4000);
        bus.ex_wr_en = 1; bus.ex_wr_addr = 5;
        #1;
        check("ld-use c1 stall", {31'd0, bus.stall}, 1);
        @(negedge clk);
        bus.ex_wr_en = 0; bus.mem_wr_en = 1; bus.mem_wr_addr = 5; bus.mem_is_load = 1;
        #1;
        check("ld-use c2 stall", {31'd0, bus.stall}, 1);
        check("ld-use c2 no redirect", {31'd0, bus.redirect}, 0);
        @(negedge clk);
        bus.mem_wr_en = 0; bus.mem_is_load = 0; bus.wb_wr_en = 1; bus.wb_wr_addr = 5;
        #1;
        check("ld-use c3 stall", {31'd0, bus.stall}, 0);
        check("ld-use c3 fwd_a", {30'd0, bus.fwd_a_sel}, 2);
        @(posedge clk); #1;
        check("ld-use redirect", {31'd0, bus.redirect}, 1);
        check("ld-use pc", bus.redirect_pc, 32'h0000_4000);

        // Branch in the delay slot during REDIR is ignored.
        @(negedge clk);
        set_idle();
        set_br(3'd1, 8, 9, 1, 1, 32'h0000_5000);
        bus.ex_wr_en = 1; bus.ex_wr_addr = 8;
        #1;
        check("slot br stall", {31'd0, bus.stall}, 0);
        @(posedge clk); #1;
        check("slot br no redirect", {31'd0, bus.redirect}, 0);
        check("slot br pc held", bus.redirect_pc, 32'h0000_4000);
        @(negedge clk);
        set_idle();

        // ALU result in EX: one stall cycle, then MEM forward, not taken.
        @(negedge clk);
        set_br(3'd3, 5, 0, 0, 0, 32'h0000_6000);
        bus.ex_wr_en = 1; bus.ex_wr_addr = 5;
        #1;
        check("alu c1 stall", {31'd0, bus.stall}, 1);
        @(negedge clk);
        bus.ex_wr_en = 0; bus.mem_wr_en = 1; bus.mem_wr_addr = 5;
        #1;
        check("alu c2 stall", {31'd0, bus.stall}, 0);
        check("alu c2 fwd_a", {30'd0, bus.fwd_a_sel}, 1);
        @(posedge clk); #1;
        check("alu no redirect", {31'd0, bus.redirect}, 0);

        // External flush in WAIT, then branch type 7 never taken.
        @(negedge clk);
        set_br(3'd0, 3, 0, 0, 1, 32'h0000_7000);
        bus.ex_wr_en = 1; bus.ex_wr_addr = 3;
        @(negedge clk);
        set_idle();
        @(negedge clk);
        set_br(3'd7, 3, 0, 0, 1, 32'h0000_7000);
        @(posedge clk); #1;
        check("type7 no redirect", {31'd0, bus.redirect}, 0);
        check("flush pc held", bus.redirect_pc, 32'h0000_4000);
        @(negedge clk);
        set_idle();

        // Reset in WAIT drops stall at once.
        @(negedge clk);
        set_br(3'd0, 3, 0, 0, 1, 32'h0000_8000);
        bus.ex_wr_en = 1; bus.ex_wr_addr = 3;
        @(negedge clk);
        #1;
        check("wait stall", {31'd0, bus.stall}, 1);
        reset = 0;
        #1;
        check("reset in wait stall", {31'd0, bus.stall}, 0);
        check("reset in wait cmp_sel", {29'd0, bus.cmp_sel}, 0);
        @(negedge clk);
        set_idle();
        reset = 1;

        // Reset during REDIR loses the pending redirect.
        @(negedge clk);
        set_br(3'd0, 3, 4, 1, 1, 32'h0000_9000);
        @(posedge clk); #1;
        check("pre-reset redirect", {31'd0, bus.redirect}, 1);
        reset = 0;
        #1;
        check("reset redir redirect", {31'd0, bus.redirect}, 0);
        check("reset redir pc", bus.redirect_pc, 0);
        do_reset();

`ifdef BRANCH_STATS_EN
        check("stats br reset", br_count, 0);
        @(negedge clk);
        set_br(3'd0, 3, 4, 1, 1, 32'h0000_A000);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        set_br(3'd2, 5, 0, 0, 1, 32'h0000_B000);
        bus.ex_wr_en = 1; bus.ex_wr_addr = 5;
        @(negedge clk);
        bus.ex_wr_en = 0; bus.mem_wr_en = 1; bus.mem_wr_addr = 5; bus.mem_is_load = 1;
        @(negedge clk);
        bus.mem_wr_en = 0; bus.mem_is_load = 0; bus.wb_wr_en = 1; bus.wb_wr_addr = 5;
        @(negedge clk);
        set_idle();
        @(negedge clk);
        set_br(3'd1, 3, 4, 1, 0, 32'h0000_C000);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        check("stats br_count",    br_count,    3);
        check("stats taken_count", taken_count, 2);
        check("stats stall_count", stall_count, 2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
